// File: rtl/decoder_mips_pipe.sv
// Registered MIPS decode stage: main/ALU control, branch resolution and SLT result,
// with a valid/ready handshake, load-use bubble insertion and taken-branch squash.
module decoder_mips_pipe #(
  parameter int DATA_W       = 32,
  parameter bit HAZARD_EN    = 1'b1,
  parameter bit BRANCH_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic              equalrsrt,
  input  logic              rsmaior,
  input  logic              rsmrt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        ctrol,
  output logic [3:0]        outsaida,
  output logic [DATA_W-1:0] rt,
  output logic              slt_mux,
  output logic              branch_taken,
  output logic              bubble,
  output logic              illegal
);

  typedef enum logic [1:0] {S_RUN, S_BUBBLE, S_SQUASH} state_t;

  state_t              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [7:0]          ctrol_q, ctrol_d;
  logic [3:0]          outsaida_q, outsaida_d;
  logic [DATA_W-1:0]   rt_q, rt_d;
  logic                slt_mux_q, slt_mux_d;
  logic                taken_q, taken_d;
  logic                bubble_q, bubble_d;
  logic                illegal_q, illegal_d;
  logic                lw_valid_q, lw_valid_d;
  logic [4:0]          lw_dest_q, lw_dest_d;

  logic [5:0] op, funct;
  logic [4:0] rs_idx, rt_idx;
  logic [7:0] dec_ctrol;
  logic [3:0] dec_alu;
  logic       dec_slt, dec_ill, is_lw, is_beq, is_bne, is_j, uses_rt, dec_taken;
  logic       load_en, hazard;

  // rsmaior travels with the instruction but nothing here decodes it.
  logic unused_ok;
  assign unused_ok = &{1'b0, rsmaior, instr[15:6]};

  assign op     = instr[31:26];
  assign rs_idx = instr[25:21];
  assign rt_idx = instr[20:16];
  assign funct  = instr[5:0];

  always_comb begin
    dec_ctrol = 8'h00;
    dec_alu   = 4'h0;
    dec_slt   = 1'b0;
    dec_ill   = 1'b0;
    is_lw     = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_j      = 1'b0;
    uses_rt   = 1'b0;
    case (op)
      6'h00: begin
        uses_rt   = 1'b1;
        dec_ctrol = 8'b1001_0000;
        case (funct)
          6'h20: dec_alu = 4'b0010;
          6'h22: dec_alu = 4'b0110;
          6'h24: dec_alu = 4'b0000;
          6'h25: dec_alu = 4'b0001;
          6'h2A: begin dec_alu = 4'b0111; dec_slt = 1'b1; end
          6'h27: dec_alu = 4'b1100;
          default: begin dec_ill = 1'b1; dec_ctrol = 8'h00; end
        endcase
      end
      6'h23: begin dec_ctrol = 8'b0111_1000; dec_alu = 4'b0010; is_lw = 1'b1; end
      6'h2B: begin dec_ctrol = 8'b0100_0100; dec_alu = 4'b0010; uses_rt = 1'b1; end
      6'h08: begin dec_ctrol = 8'b0101_0000; dec_alu = 4'b0010; end
      6'h0A: begin dec_ctrol = 8'b0101_0000; dec_alu = 4'b0111; dec_slt = 1'b1; end
      6'h04: begin dec_ctrol = 8'b0000_0010; dec_alu = 4'b0110; is_beq = 1'b1; uses_rt = 1'b1; end
      6'h05: begin dec_ctrol = 8'b0000_0010; dec_alu = 4'b0110; is_bne = 1'b1; uses_rt = 1'b1; end
      6'h02: begin dec_ctrol = 8'b0000_0001; is_j = 1'b1; end
      default: dec_ill = 1'b1;
    endcase
  end

  assign dec_taken = (is_beq & equalrsrt) | (is_bne & ~equalrsrt) | is_j;
  assign load_en   = ~out_valid_q | out_ready;

  // A pending squash takes priority, so hazards are only looked for in RUN.
  assign hazard = HAZARD_EN & in_valid & (state_q == S_RUN) & lw_valid_q & ~is_j &
                  ((rs_idx == lw_dest_q) | (uses_rt & (rt_idx == lw_dest_q)));

  assign in_ready = rst_n & load_en & ~hazard;

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    ctrol_d      = ctrol_q;
    outsaida_d   = outsaida_q;
    rt_d         = rt_q;
    slt_mux_d    = slt_mux_q;
    taken_d      = taken_q;
    bubble_d     = bubble_q;
    illegal_d    = illegal_q;
    lw_valid_d   = lw_valid_q;
    lw_dest_d    = lw_dest_q;
    if (load_en) begin
      out_valid_d = 1'b0;
      ctrol_d     = 8'h00;
      outsaida_d  = 4'h0;
      rt_d        = '0;
      slt_mux_d   = 1'b0;
      taken_d     = 1'b0;
      bubble_d    = 1'b0;
      illegal_d   = 1'b0;
      if (hazard) begin
        out_valid_d = 1'b1;
        bubble_d    = 1'b1;
        lw_valid_d  = 1'b0;
        state_d     = S_BUBBLE;
      end else if (in_valid) begin
        if (state_q == S_SQUASH) begin
          state_d = S_RUN;
        end else begin
          out_valid_d = 1'b1;
          ctrol_d     = dec_ctrol;
          outsaida_d  = dec_alu;
          rt_d        = dec_slt ? {{(DATA_W-1){1'b0}}, rsmrt} : '0;
          slt_mux_d   = dec_slt;
          taken_d     = dec_taken;
          illegal_d   = dec_ill;
          lw_valid_d  = is_lw & (rt_idx != 5'd0);
          lw_dest_d   = rt_idx;
          state_d     = (BRANCH_FLUSH && dec_taken) ? S_SQUASH : S_RUN;
        end
      end else if (state_q == S_BUBBLE) begin
        state_d = S_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      out_valid_q <= 1'b0;
      ctrol_q     <= 8'h00;
      outsaida_q  <= 4'h0;
      rt_q        <= '0;
      slt_mux_q   <= 1'b0;
      taken_q     <= 1'b0;
      bubble_q    <= 1'b0;
      illegal_q   <= 1'b0;
      lw_valid_q  <= 1'b0;
      lw_dest_q   <= 5'd0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      ctrol_q     <= ctrol_d;
      outsaida_q  <= outsaida_d;
      rt_q        <= rt_d;
      slt_mux_q   <= slt_mux_d;
      taken_q     <= taken_d;
      bubble_q    <= bubble_d;
      illegal_q   <= illegal_d;
      lw_valid_q  <= lw_valid_d;
      lw_dest_q   <= lw_dest_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign ctrol        = ctrol_q;
  assign outsaida     = outsaida_q;
  assign rt           = rt_q;
  assign slt_mux      = slt_mux_q;
  assign branch_taken = taken_q;
  assign bubble       = bubble_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_decoder_mips_pipe.sv
// Bench for decoder_mips_pipe: two instances (hazard+flush, and neither) driven in
// lockstep and compared every cycle against a flag-based reference model.
module tb_decoder_mips_pipe;
  typedef logic [48:0] obs_t; // {ov, ctrol[8], alu[4], rt[32], slt, taken, bubble, illegal}

  logic        clk = 1'b0;
  logic        rst_n, in_valid, equalrsrt, rsmaior, rsmrt, out_ready;
  logic [31:0] instr;
  logic        in_ready_s [2];
  logic        ov_s [2];
  logic [7:0]  ctrol_s [2];
  logic [3:0]  alu_s [2];
  logic [31:0] rt_s [2];
  logic        slt_s [2];
  logic        taken_s [2];
  logic        bub_s [2];
  logic        ill_s [2];

  int checks = 0;
  int errors = 0;

  obs_t m_out [2];
  bit   m_bub [2];
  bit   m_sq  [2];
  int   m_lw  [2];
  bit   m_haz_en [2];
  bit   m_flush  [2];

  always #5 clk = ~clk;

  decoder_mips_pipe #(.DATA_W(32), .HAZARD_EN(1'b1), .BRANCH_FLUSH(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s[0]), .instr(instr),
    .equalrsrt(equalrsrt), .rsmaior(rsmaior), .rsmrt(rsmrt), .out_valid(ov_s[0]),
    .out_ready(out_ready), .ctrol(ctrol_s[0]), .outsaida(alu_s[0]), .rt(rt_s[0]),
    .slt_mux(slt_s[0]), .branch_taken(taken_s[0]), .bubble(bub_s[0]), .illegal(ill_s[0]));

  decoder_mips_pipe #(.DATA_W(32), .HAZARD_EN(1'b0), .BRANCH_FLUSH(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s[1]), .instr(instr),
    .equalrsrt(equalrsrt), .rsmaior(rsmaior), .rsmrt(rsmrt), .out_valid(ov_s[1]),
    .out_ready(out_ready), .ctrol(ctrol_s[1]), .outsaida(alu_s[1]), .rt(rt_s[1]),
    .slt_mux(slt_s[1]), .branch_taken(taken_s[1]), .bubble(bub_s[1]), .illegal(ill_s[1]));

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rtf, input logic [5:0] fn);
    return {op, rs, rtf, 10'd0, fn};
  endfunction

  function automatic obs_t dut_obs(input int i);
    return {ov_s[i], ctrol_s[i], alu_s[i], rt_s[i], slt_s[i], taken_s[i], bub_s[i], ill_s[i]};
  endfunction

  // Decoded instruction as the decode table describes it.
  function automatic obs_t ref_decode(input logic [31:0] ins, input bit eq, input bit lt);
    logic [7:0] c;
    logic [3:0] a;
    bit s, ill, tk;
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    c = 8'h00; a = 4'h0; s = 0; ill = 0; tk = 0;
    if (op == 6'h00) begin
      c = 8'h90;
      if (fn == 6'h20) a = 4'd2;
      else if (fn == 6'h22) a = 4'd6;
      else if (fn == 6'h24) a = 4'd0;
      else if (fn == 6'h25) a = 4'd1;
      else if (fn == 6'h2A) begin a = 4'd7; s = 1; end
      else if (fn == 6'h27) a = 4'd12;
      else begin c = 8'h00; ill = 1; end
    end else if (op == 6'h23) begin c = 8'h78; a = 4'd2; end
    else if (op == 6'h2B) begin c = 8'h44; a = 4'd2; end
    else if (op == 6'h08) begin c = 8'h50; a = 4'd2; end
    else if (op == 6'h0A) begin c = 8'h50; a = 4'd7; s = 1; end
    else if (op == 6'h04) begin c = 8'h02; a = 4'd6; tk = eq; end
    else if (op == 6'h05) begin c = 8'h02; a = 4'd6; tk = !eq; end
    else if (op == 6'h02) begin c = 8'h01; tk = 1; end
    else ill = 1;
    return {1'b1, c, a, (s ? {31'd0, lt} : 32'd0), s, tk, 1'b0, ill};
  endfunction

  function automatic bit ref_hazard(input int i, input logic [31:0] ins, input bit iv);
    int op, rs, rtf;
    bit uses_rt;
    op  = int'(ins[31:26]);
    rs  = int'(ins[25:21]);
    rtf = int'(ins[20:16]);
    uses_rt = (op == 0) || (op == 'h2B) || (op == 4) || (op == 5);
    return m_haz_en[i] && iv && !m_sq[i] && !m_bub[i] && (m_lw[i] >= 0) && (op != 2) &&
           ((rs == m_lw[i]) || (uses_rt && rtf == m_lw[i]));
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input obs_t obs, input obs_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check in_ready, clock, advance model, check registered outputs.
  task automatic step(input bit rstn, input bit iv, input logic [31:0] ins,
                      input bit eq, input bit lt, input bit ordy);
    bit le [2];
    bit hz [2];
    obs_t b;
    rst_n = rstn; in_valid = iv; instr = ins; equalrsrt = eq; rsmrt = lt;
    rsmaior = 1'($urandom); out_ready = ordy;
    #1;
    for (int i = 0; i < 2; i++) begin
      le[i] = !m_out[i][48] || ordy;
      hz[i] = ref_hazard(i, ins, iv);
      check_bit($sformatf("in_ready%0d", i), in_ready_s[i], rstn && le[i] && !hz[i]);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rstn) begin
        m_out[i] = '0; m_bub[i] = 0; m_sq[i] = 0; m_lw[i] = -1;
      end else if (le[i]) begin
        if (hz[i]) begin
          b = '0; b[48] = 1'b1; b[1] = 1'b1;
          m_out[i] = b; m_lw[i] = -1; m_bub[i] = 1;
        end else if (iv) begin
          m_bub[i] = 0;
          if (m_sq[i]) begin
            m_out[i] = '0; m_sq[i] = 0;
          end else begin
            m_out[i] = ref_decode(ins, eq, lt);
            m_lw[i] = (ins[31:26] == 6'h23 && ins[20:16] != 5'd0) ? int'(ins[20:16]) : -1;
            m_sq[i] = m_flush[i] && m_out[i][2];
          end
        end else begin
          m_out[i] = '0; m_bub[i] = 0;
        end
      end
    end
    #1;
    for (int i = 0; i < 2; i++) check_vec($sformatf("outputs%0d", i), dut_obs(i), m_out[i]);
    $display("step rst_n=%0d iv=%0d instr=%h ordy=%0d | ov0=%0d ctrol0=%b alu0=%b bub0=%0d tk0=%0d | ov1=%0d",
             rstn, iv, ins, ordy, ov_s[0], ctrol_s[0], alu_s[0], bub_s[0], taken_s[0], ov_s[1]);
  endtask

  initial begin
    obs_t held;
    logic [5:0] ops [9];
    logic [5:0] fns [6];
    logic [5:0] op, fn;
    logic [31:0] ins;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h0A, 6'h04, 6'h05, 6'h02, 6'h00};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
    m_haz_en = '{1'b1, 1'b0};
    m_flush  = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin m_out[i] = '0; m_bub[i] = 0; m_sq[i] = 0; m_lw[i] = -1; end

    step(0, 0, 32'd0, 0, 0, 1);
    step(0, 1, mk(6'h00, 5'd1, 5'd2, 6'h20), 0, 0, 1);
    check_vec("reset_state", dut_obs(0), '0);

    // ADD
    step(1, 1, mk(6'h00, 5'd1, 5'd2, 6'h20), 0, 0, 1);
    check_bit("add_valid", ov_s[0], 1'b1);
    check_vec("add_ctrol", 49'(ctrol_s[0]), 49'(8'b1001_0000));
    check_vec("add_alu", 49'(alu_s[0]), 49'(4'b0010));

    // LW r8 then ADD reading r8
    step(1, 1, mk(6'h23, 5'd1, 5'd8, 6'h00), 0, 0, 1);
    check_vec("lw_ctrol", 49'(ctrol_s[0]), 49'(8'b0111_1000));
    step(1, 1, mk(6'h00, 5'd8, 5'd3, 6'h20), 0, 0, 1);
    check_bit("lu_bubble", bub_s[0], 1'b1);
    check_vec("lu_ctrol0", 49'(ctrol_s[0]), 49'd0);
    step(1, 1, mk(6'h00, 5'd8, 5'd3, 6'h20), 0, 0, 1);
    check_bit("lu_add_bubble", bub_s[0], 1'b0);
    check_vec("lu_add_ctrol", 49'(ctrol_s[0]), 49'(8'b1001_0000));

    // BEQ taken, ADDI squashed, next decodes
    step(1, 1, mk(6'h04, 5'd1, 5'd1, 6'h00), 1, 0, 1);
    check_bit("beq_taken", taken_s[0], 1'b1);
    step(1, 1, mk(6'h08, 5'd2, 5'd3, 6'h00), 0, 0, 1);
    check_bit("beq_squash", ov_s[0], 1'b0);
    check_bit("beq_slot_nf", ov_s[1], 1'b1);
    step(1, 1, mk(6'h00, 5'd4, 5'd5, 6'h22), 0, 0, 1);
    check_bit("after_squash", ov_s[0], 1'b1);

    // BNE not taken; J on both flush settings
    step(1, 1, mk(6'h05, 5'd1, 5'd1, 6'h00), 1, 0, 1);
    check_bit("bne_nt", taken_s[0], 1'b0);
    step(1, 1, mk(6'h08, 5'd2, 5'd3, 6'h00), 0, 0, 1);
    check_bit("bne_next", ov_s[0], 1'b1);
    step(1, 1, mk(6'h02, 5'd0, 5'd0, 6'h00), 0, 0, 1);
    check_bit("j_taken", taken_s[1], 1'b1);
    step(1, 1, mk(6'h08, 5'd2, 5'd3, 6'h00), 0, 0, 1);
    check_bit("j_slot_nf", ov_s[1], 1'b1);
    check_bit("j_squash", ov_s[0], 1'b0);

    // SLTI
    step(1, 1, mk(6'h0A, 5'd2, 5'd3, 6'h00), 0, 1, 1);
    check_vec("slti_rt1", 49'(rt_s[0]), 49'd1);
    check_bit("slti_mux", slt_s[0], 1'b1);
    check_vec("slti_alu", 49'(alu_s[0]), 49'(4'b0111));
    step(1, 1, mk(6'h0A, 5'd2, 5'd3, 6'h00), 0, 0, 1);
    check_vec("slti_rt0", 49'(rt_s[0]), 49'd0);

    // Backpressure holds outputs
    held = m_out[0];
    for (int k = 0; k < 3; k++) begin
      step(1, 1, mk(6'h00, 5'd6, 5'd7, 6'h25), 0, 0, 0);
      check_vec("stall_hold", dut_obs(0), held);
    end

    // Reset while a squash is pending
    step(1, 1, mk(6'h04, 5'd1, 5'd1, 6'h00), 1, 0, 1);
    step(0, 1, mk(6'h08, 5'd2, 5'd3, 6'h00), 0, 0, 1);
    check_vec("rst_squash", dut_obs(0), '0);
    step(1, 1, mk(6'h08, 5'd2, 5'd3, 6'h00), 0, 0, 1);
    check_bit("rst_squash_run", ov_s[0], 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 2500; n++) begin
      int k;
      k = $urandom_range(0, 9);
      op = (k == 9) ? 6'($urandom_range(0, 63)) : ops[k];
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 5)];
      ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 10'($urandom), fn};
      step($urandom_range(0, 99) != 0, $urandom_range(0, 4) != 0, ins,
           1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
